// File: rtl/regfile_context_engine_if.sv
// Command, register-file and save/restore stream signals of the context engine.
// master = engine side, slave = register file / stream / requester side.
interface regfile_context_engine_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [ADDR_W-1:0] cmd_first;
    logic [ADDR_W-1:0] cmd_last;
    logic [ADDR_W-1:0] rf_read_addr;
    logic [DATA_W-1:0] rf_read_data;
    logic [ADDR_W-1:0] rf_write_addr;
    logic [DATA_W-1:0] rf_write_data;
    logic              sv_valid;
    logic              sv_ready;
    logic [DATA_W-1:0] sv_data;
    logic              sv_last;
    logic              rs_valid;
    logic              rs_ready;
    logic [DATA_W-1:0] rs_data;
    logic              busy;
    logic              done;

    modport master (
        input  cmd_valid, cmd_op, cmd_first, cmd_last, rf_read_data,
               sv_ready, rs_valid, rs_data,
        output cmd_ready, rf_read_addr, rf_write_addr, rf_write_data,
               sv_valid, sv_data, sv_last, rs_ready, busy, done
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_first, cmd_last, rf_read_data,
               sv_ready, rs_valid, rs_data,
        input  cmd_ready, rf_read_addr, rf_write_addr, rf_write_data,
               sv_valid, sv_data, sv_last, rs_ready, busy, done
    );
endinterface

// File: rtl/regfile_context_engine.sv
// Save/restore sequencer streaming a wrapping register range; one beat per cycle, save data same-cycle.
// Stalls on sv_ready/rs_valid; restore write is registered for one cycle. SKIP_R0_EN drops R0 from the range.
module regfile_context_engine #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    regfile_context_engine_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_SAVE, S_RESTORE, S_DONE} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_last;
    logic              r_cmd_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_sv_valid;
    logic              r_rs_ready;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;

    logic [ADDR_W-1:0] w_first;
    logic [ADDR_W-1:0] w_last;
    logic              w_empty;
    logic              w_at_last;
    logic              w_sv_hs;
    logic              w_rs_hs;

    function automatic logic [ADDR_W-1:0] f_next(input logic [ADDR_W-1:0] idx);
        logic [ADDR_W-1:0] n;
        n = ADDR_W'((32'(idx) + 32'd1) % NUM_REGS);
`ifdef SKIP_R0_EN
        if (n == '0) n = ADDR_W'(1);
`endif
        return n;
    endfunction

`ifdef SKIP_R0_EN
    // Clip R0 off either end of the range; a range of only R0 is empty.
    assign w_first = (bus.cmd_first == '0) ? ADDR_W'(1) : bus.cmd_first;
    assign w_last  = (bus.cmd_last == '0) ? ADDR_W'(NUM_REGS - 1) : bus.cmd_last;
    assign w_empty = (bus.cmd_first == '0) && (bus.cmd_last == '0);
`else
    assign w_first = bus.cmd_first;
    assign w_last  = bus.cmd_last;
    assign w_empty = 1'b0;
`endif

    assign w_at_last = (r_idx == r_last);
    assign w_sv_hs   = r_sv_valid && bus.sv_ready;
    assign w_rs_hs   = r_rs_ready && bus.rs_valid;

    assign bus.cmd_ready     = r_cmd_ready;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.sv_valid      = r_sv_valid;
    assign bus.rs_ready      = r_rs_ready;
    assign bus.rf_read_addr  = r_idx;
    assign bus.sv_data       = r_sv_valid ? bus.rf_read_data : '0;
    assign bus.sv_last       = r_sv_valid && w_at_last;
    assign bus.rf_write_addr = r_wr_addr;
    assign bus.rf_write_data = r_wr_data;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_last      <= '0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sv_valid  <= 1'b0;
            r_rs_ready  <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            // Write port falls back to the R0 no-op unless a beat lands this cycle.
            r_done    <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_idx       <= w_first;
                        r_last      <= w_last;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_empty) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (bus.cmd_op) begin
                            r_state    <= S_RESTORE;
                            r_rs_ready <= 1'b1;
                        end else begin
                            r_state    <= S_SAVE;
                            r_sv_valid <= 1'b1;
                        end
                    end
                end
                S_SAVE: begin
                    if (w_sv_hs) begin
                        if (w_at_last) begin
                            r_state    <= S_DONE;
                            r_sv_valid <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_idx <= f_next(r_idx);
                        end
                    end
                end
                S_RESTORE: begin
                    if (w_rs_hs) begin
                        r_wr_addr <= r_idx;
                        r_wr_data <= bus.rs_data;
                        if (w_at_last) begin
                            r_state    <= S_DONE;
                            r_rs_ready <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_idx <= f_next(r_idx);
                        end
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_sv_valid  <= 1'b0;
                    r_rs_ready  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_context_engine.sv
// Randomized bench for regfile_context_engine: behavioural register file plus a range/contents reference model.
module tb_regfile_context_engine;
`ifdef SKIP_R0_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk;
    logic rst_n;
    regfile_context_engine_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    regfile_context_engine #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(32)) u_dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment register file: negedge commit, R0 hardwired to zero.
    logic [31:0] rf[16];
    logic [31:0] load_val[16];
    logic        tb_load;
    always @(negedge clk) begin
        if (tb_load) begin
            for (int i = 0; i < 16; i++) rf[i] <= load_val[i];
        end else if (bus.rf_write_addr != 4'd0) begin
            rf[bus.rf_write_addr] <= bus.rf_write_data;
        end
    end
    assign bus.rf_read_data = rf[bus.rf_read_addr];

    logic [31:0] mdl[16];
    int exp_seq[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ordered register indices covered by a command, straight from the range rule.
    task automatic build_seq(input int first, input int last);
        int n;
        exp_seq.delete();
        n = (((last - first) % 16) + 16) % 16 + 1;
        for (int i = 0; i < n; i++) begin
            int r;
            r = (first + i) % 16;
            if (!(SKIP && r == 0)) exp_seq.push_back(r);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_sv_valid"}, bus.sv_valid, 0);
        chk({tag, "_rs_ready"}, bus.rs_ready, 0);
        chk({tag, "_wr_addr"}, bus.rf_write_addr, 0);
        chk({tag, "_wr_data"}, bus.rf_write_data, 0);
    endtask

    task automatic check_regs();
        for (int i = 0; i < 16; i++) chk($sformatf("reg%0d", i), rf[i], mdl[i]);
    endtask

    task automatic issue(input bit op, input int first, input int last);
        chk("cmd_ready_before_issue", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_first = 4'(first);
        bus.cmd_last  = 4'(last);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic run_save(input int first, input int last, input int rdy_pct);
        int k;
        bit stalled, got_last, done_seen;
        logic [31:0] held;
        build_seq(first, last);
        issue(1'b0, first, last);
        k = 0; stalled = 0; got_last = 0; done_seen = 0; held = '0;
        for (int cyc = 0; cyc < 500 && !done_seen; cyc++) begin
            if (bus.done) begin
                done_seen = 1;
                chk("save_beats", k, exp_seq.size());
                chk("save_busy_in_done", bus.busy, 1);
                chk("save_sv_valid_in_done", bus.sv_valid, 0);
            end else begin
                chk("save_cmd_ready_busy", bus.cmd_ready, 0);
                chk("save_rs_ready", bus.rs_ready, 0);
                chk("save_sv_valid", bus.sv_valid, 1);
                chk("save_no_write", bus.rf_write_addr, 0);
                if (got_last) chk("save_done_after_last", bus.done, 1);
                if (stalled) chk("save_stall_stable", bus.sv_data, held);
                bus.sv_ready = ($urandom_range(99) < rdy_pct);
                if (bus.sv_ready) begin
                    if (k < exp_seq.size()) begin
                        chk($sformatf("save_data_beat%0d", k), bus.sv_data, mdl[exp_seq[k]]);
                        chk($sformatf("save_last_beat%0d", k), bus.sv_last, (k == exp_seq.size() - 1));
                    end
                    got_last = bus.sv_last;
                    stalled = 0;
                    k++;
                end else begin
                    stalled = 1;
                    held = bus.sv_data;
                end
            end
            tick();
        end
        bus.sv_ready = 1'b0;
        chk("save_timeout", done_seen, 1);
        check_idle("after_save");
    endtask

    // abort_after >= 0: pull reset once that many beats have been accepted.
    task automatic run_restore(input int first, input int last, input int vld_pct, input int abort_after);
        int k;
        bit got_last, done_seen;
        logic [3:0]  exp_wa;
        logic [31:0] exp_wd;
        build_seq(first, last);
        issue(1'b1, first, last);
        k = 0; got_last = 0; done_seen = 0; exp_wa = '0; exp_wd = '0;
        for (int cyc = 0; cyc < 500 && !done_seen; cyc++) begin
            chk("rst_wr_addr", bus.rf_write_addr, exp_wa);
            chk("rst_wr_data", bus.rf_write_data, exp_wd);
            exp_wa = '0;
            exp_wd = '0;
            if (bus.done) begin
                done_seen = 1;
                chk("restore_beats", k, exp_seq.size());
                chk("restore_busy_in_done", bus.busy, 1);
                chk("restore_rs_ready_in_done", bus.rs_ready, 0);
            end else if (k == abort_after) begin
                rst_n = 1'b0;
                bus.rs_valid = 1'b1;
                tick();
                check_idle("abort");
                rst_n = 1'b1;
                for (int j = 0; j < 4; j++) begin
                    tick();
                    chk("abort_no_write", bus.rf_write_addr, 0);
                    chk("abort_rs_ready", bus.rs_ready, 0);
                end
                bus.rs_valid = 1'b0;
                return;
            end else begin
                chk("restore_cmd_ready_busy", bus.cmd_ready, 0);
                chk("restore_sv_valid", bus.sv_valid, 0);
                chk("restore_rs_ready", bus.rs_ready, 1);
                if (got_last) chk("restore_done_after_last", bus.done, 1);
                bus.rs_valid = ($urandom_range(99) < vld_pct);
                bus.rs_data  = $urandom;
                if (bus.rs_valid) begin
                    if (k < exp_seq.size()) begin
                        exp_wa = 4'(exp_seq[k]);
                        exp_wd = bus.rs_data;
                        if (exp_seq[k] != 0) mdl[exp_seq[k]] = bus.rs_data;
                    end
                    got_last = (k >= exp_seq.size() - 1);
                    k++;
                end
            end
            tick();
        end
        bus.rs_valid = 1'b0;
        chk("restore_timeout", done_seen, 1);
        check_idle("after_restore");
    endtask

    initial begin
        rst_n         = 1'b0;
        tb_load       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_first = '0;
        bus.cmd_last  = '0;
        bus.sv_ready  = 1'b0;
        bus.rs_valid  = 1'b0;
        bus.rs_data   = '0;

        for (int i = 0; i < 16; i++) load_val[i] = (i == 0) ? 32'd0 : 32'h100 + 32'(i);
        tb_load = 1'b1;
        @(negedge clk);
        #1 tb_load = 1'b0;
        for (int i = 0; i < 16; i++) mdl[i] = load_val[i];

        tick();
        tick();
        check_idle("reset");
        chk("reset_sv_data", bus.sv_data, 0);
        chk("reset_sv_last", bus.sv_last, 0);
        chk("reset_rd_addr", bus.rf_read_addr, 0);
        rst_n = 1'b1;
        tick();

        run_save(0, 15, 100);
        run_save(14, 1, 50);
        run_restore(3, 5, 100, -1);
        check_regs();
        run_restore(7, 12, 40, -1);
        check_regs();
        run_restore(4, 11, 100, 2);
        check_regs();
        run_save(0, 2, 100);
        run_save(0, 0, 100);
        run_restore(15, 1, 70, -1);
        check_regs();

        for (int t = 0; t < 30; t++) begin
            int f, l, p;
            f = $urandom_range(15);
            l = $urandom_range(15);
            p = $urandom_range(100, 30);
            if ($urandom_range(1) == 1) begin
                run_restore(f, l, p, -1);
                check_regs();
            end else begin
                run_save(f, l, p);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/regfile_context_engine.md
Name: regfile_context_engine

Overview:
- Sequencer that dumps a contiguous range of the 16x32 register file to a streaming sink (save), or loads it from a streaming source (restore).
- Used for context switch and debug snapshot.
- Drives the register file's read-address and write-address/data ports while the core pipeline is stalled (busy=1). The engine is the sole register-file writer while busy.
- Runs on posedge clk; the register file commits writes on negedge clk.

Parameters:
- NUM_REGS, 16, number of architectural registers (power of two)
- ADDR_W, 4, register index width, log2(NUM_REGS)
- DATA_W, 32, register width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  engine idle, command accepted when cmd_valid&&cmd_ready
- cmd_op  in  1  0=save, 1=restore
- cmd_first  in  ADDR_W  first register index
- cmd_last  in  ADDR_W  last register index (inclusive)
- rf_read_addr  out  ADDR_W  to register file read port A address
- rf_read_data  in  DATA_W  from register file read port A data (combinational)
- rf_write_addr  out  ADDR_W  to register file write address
- rf_write_data  out  DATA_W  to register file write data
- sv_valid  out  1  save stream beat valid
- sv_ready  in  1  save stream sink ready
- sv_data  out  DATA_W  save stream data
- sv_last  out  1  final save beat
- rs_valid  in  1  restore stream beat valid
- rs_ready  out  1  engine accepts restore beat
- rs_data  in  DATA_W  restore stream data
- busy  out  1  high in SAVE/RESTORE/DONE
- done  out  1  one-cycle pulse at completion

Behaviour:
- Reset: state=IDLE, idx=0, every output 0 except cmd_ready=1; rf_write_addr=0, rf_write_data=0.
- Idle-write rule: the register file writes on every negedge with no enable. Whenever no restore write is pending, rf_write_addr=0 and rf_write_data=0 (R0 is hardwired zero), so the write is a no-op.
- States: IDLE, SAVE, RESTORE, DONE.
- IDLE:
  - cmd_ready=1.
  - On accept: latch first/last; idx<=first; go to SAVE (op=0) or RESTORE (op=1).
- Range:
  - idx advances by +1 mod NUM_REGS from first to last inclusive.
  - first>last wraps, e.g. 14..1 = 14,15,0,1.
  - Beat count = ((last-first) mod NUM_REGS)+1; first==last gives one beat.
- SAVE:
  - rf_read_addr=idx.
  - sv_valid=1, sv_data=rf_read_data (same cycle).
  - sv_last=(idx==last).
  - Outputs stay stable while sv_ready=0.
  - On sv_valid&&sv_ready: if sv_last, go to DONE, else idx<=idx+1.
- RESTORE:
  - rs_ready=1.
  - On rs_valid&&rs_ready at posedge N:
    - rf_write_addr<=idx and rf_write_data<=rs_data, held from posedge N to N+1; the register file commits at the negedge between them.
    - At posedge N+1 they return to 0/0 unless another beat is accepted.
    - If idx==last, go to DONE; else idx<=idx+1.
  - Back-to-back beats give one register write per cycle.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - For restore, the final write's negedge commit falls inside the DONE cycle, so the registers are valid once busy drops.
- busy=1 in SAVE, RESTORE and DONE.
- cmd_valid while not IDLE is ignored (cmd_ready=0).
- Reset mid-operation: state returns to IDLE and all outputs clear on the next posedge. Writes already committed remain (no rollback). No partial beat is emitted.
- sv_valid and rs_ready are never both 1.

Optional Feature:
- Macro: SKIP_R0_EN.
- Defined: index 0 is excluded from the sequence.
  - Save emits no beat for R0.
  - Restore consumes no beat for R0.
  - sv_last/done are computed against the last non-zero index.
  - A range containing only R0 goes directly IDLE->DONE with zero beats.
- Undefined:
  - R0 is included.
  - Save emits 0 for it.
  - The restore beat for R0 is consumed; the register file discards the write.

Test Plan:
- Preload R1..R15 = 0x100+i; save first=0 last=15 with sv_ready=1 -> 16 consecutive beats, data 0,0x101..0x10F, sv_last on beat 16, done pulses the cycle after.
- Save first=14 last=1 with sv_ready toggled 1/0 -> beats R14,R15,R0,R1 in order; data stable during stalls; 4 beats total.
- Restore first=3 last=5, rs_data 0xA,0xB,0xC back-to-back -> R3=0xA, R4=0xB, R5=0xC; all other registers unchanged; rf_write_addr=0 in idle cycles.
- Restore with rs_valid gaps -> one write per accepted beat; no writes during gaps (rf_write_addr=0).
- rst_n low after 2 of 8 restore beats -> IDLE next cycle, cmd_ready=1, busy=0, no further writes.
- SKIP_R0_EN defined, save first=0 last=2 -> 2 beats (R1,R2); command 0..0 -> done with zero beats.
